// File: rtl/radix2_divider_pkg.sv
// Shared types for the radix-2 divider: 64/128-bit words, FSM state enum,
// and the iteration counter width used at the default operand width.
package radix2_divider_pkg;

    typedef logic [63:0]  u64;
    typedef logic [127:0] u128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/radix2_divider.sv
// Unsigned restoring radix-2 divider: one shift-subtract step per cycle, MSB first.
// Optional macro RADIX2_DIVIDER_FAST_PATH_EN finishes b=0 / a<b requests in one cycle.
//
// Handshake: the initiator raises valid and holds a/b stable until done pulses;
// dropping valid while BUSY aborts the operation and leaves res untouched.
module radix2_divider
    import radix2_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] res,
    output div_state_t         dbg_state
);

    localparam int CW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t state, state_nxt;

    logic [WIDTH:0]       r_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     b_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   res_q;

    logic [WIDTH:0]       r_sh;
    logic [WIDTH:0]       r_step;
    logic [WIDTH-1:0]     q_step;
    logic                 ge;

    // Single restoring step on the shifted {R,Q} pair.
    always_comb begin
        r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        ge     = (r_sh >= {1'b0, b_q});
        r_step = ge ? (r_sh - {1'b0, b_q}) : r_sh;
        q_step = {q_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid) begin
`ifdef RADIX2_DIVIDER_FAST_PATH_EN
                    if ((b == '0) || (a < b)) state_nxt = DONE;
                    else                      state_nxt = BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (!valid)             state_nxt = IDLE;
                else if (cnt_q == LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            q_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        r_q   <= '0;
                        q_q   <= a;
                        b_q   <= b;
                        cnt_q <= '0;
`ifdef RADIX2_DIVIDER_FAST_PATH_EN
                        if (b == '0)  res_q <= {a, {WIDTH{1'b1}}};
                        else if (a < b) res_q <= {a, {WIDTH{1'b0}}};
`endif
                    end
                end
                BUSY: begin
                    if (valid) begin
                        r_q   <= r_step;
                        q_q   <= q_step;
                        cnt_q <= cnt_q + 1'b1;
                        // Result is captured on the final step so it is valid alongside done.
                        if (cnt_q == LAST) res_q <= {r_step[WIDTH-1:0], q_step};
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = (state == DONE);
    assign res       = res_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_radix2_divider.sv
// Directed self-checking bench for radix2_divider (WIDTH=64); expected cycles
// follow RADIX2_DIVIDER_FAST_PATH_EN when it is defined for the build.
module tb_radix2_divider;
    import radix2_divider_pkg::*;

    localparam int W = 64;

    logic           clk;
    logic           reset;
    logic           valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           done;
    logic [2*W-1:0] res;
    div_state_t     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_res;
    logic [2*W-1:0] exp_q[$];

    radix2_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .a         (a),
        .b         (b),
        .done      (done),
        .res       (res),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Caller is just past a rising edge (cycle 0). Raises valid, waits for done,
    // drops valid in the done cycle and checks timing, result and pulse count.
    task automatic do_div(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int exp_cycle);
        logic [2*W-1:0] exp_res;
        int done_cycle;
        int pulses;
        exp_res    = exp_q.pop_front();
        done_cycle = -1;
        pulses     = 0;
        a     = av;
        b     = bv;
        valid = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            if (k == 32 && exp_cycle > 32)
                check_val({tag, "_res_hold"}, res, last_res);
            if (done) begin
                pulses++;
                if (done_cycle < 0) begin
                    done_cycle = k;
                    check_val({tag, "_res"}, res, exp_res);
                    valid = 1'b0;
                end
            end
        end
        check_val({tag, "_cycle"}, 128'(done_cycle), 128'(exp_cycle));
        check_val({tag, "_pulses"}, 128'(pulses), 128'd1);
        last_res = exp_res;
    endtask

    initial begin
        int fast_cycle;
        int done_cnt;
        int first_done;
        int second_done;
        logic [2*W-1:0] res_first;
        logic [2*W-1:0] res_second;
`ifdef RADIX2_DIVIDER_FAST_PATH_EN
        fast_cycle = 1;
`else
        fast_cycle = 65;
`endif
        reset    = 1'b0;
        valid    = 1'b0;
        a        = '0;
        b        = '0;
        last_res = '0;
        #12;
        check_val("rst_done", 128'(done), 128'd0);
        check_val("rst_res", res, 128'd0);
        check_val("rst_state", 128'(dbg_state), 128'(IDLE));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Expected results are {remainder, quotient}
        exp_q.push_back({64'd2, 64'd14});
        do_div("d100_7", 64'd100, 64'd7, 65);
        exp_q.push_back({64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        do_div("dmax_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65);
        exp_q.push_back({64'd0, 64'd1});
        do_div("dmax_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        exp_q.push_back({64'd5, 64'hFFFF_FFFF_FFFF_FFFF});
        do_div("d5_0", 64'd5, 64'd0, fast_cycle);
        exp_q.push_back({64'd3, 64'd0});
        do_div("d3_9", 64'd3, 64'd9, fast_cycle);

        // Abort: valid dropped in cycle 30
        a = 64'd1000; b = 64'd3; valid = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (k == 30) valid = 1'b0;
            if (k == 31) check_val("abort_state", 128'(dbg_state), 128'(IDLE));
        end
        check_val("abort_done", 128'(done_cnt), 128'd0);
        check_val("abort_res", res, last_res);
        exp_q.push_back({64'd1, 64'd333});
        do_div("d1000_3", 64'd1000, 64'd3, 65);

        // Asynchronous reset in cycle 40 of an operation
        a = 64'd12345; b = 64'd11; valid = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_done", 128'(done), 128'd0);
        check_val("arst_res", res, 128'd0);
        check_val("arst_state", 128'(dbg_state), 128'(IDLE));
        valid = 1'b0;
        #1;
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || dbg_state != IDLE) done_cnt++;
        end
        check_val("arst_idle", 128'(done_cnt), 128'd0);

        // Back-to-back with valid held continuously
        a = 64'd100; b = 64'd7; valid = 1'b1;
        done_cnt = 0; first_done = -1; second_done = -1;
        res_first = '0; res_second = '0;
        for (int k = 1; k <= 135; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = k; res_first = res; a = 64'd200;
                end else if (second_done < 0) begin
                    second_done = k; res_second = res; valid = 1'b0;
                end
            end
        end
        valid = 1'b0;
        check_val("b2b_first_cycle", 128'(first_done), 128'd65);
        check_val("b2b_first_res", res_first, {64'd2, 64'd14});
        check_val("b2b_second_cycle", 128'(second_done), 128'd131);
        check_val("b2b_second_res", res_second, {64'd4, 64'd28});
        check_val("b2b_pulses", 128'(done_cnt), 128'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
